// File: rtl/data_mem_pkg.sv
// Shared data-RAM definitions: bus widths, default depth, access-length encodings.
// Also holds the address range test shared by the read and write ports.
package data_mem_pkg;

    localparam int RAM_ADDR_BUS   = 32;
    localparam int RAM_DATA_BUS   = 32;
    localparam int DATA_MEM_DEPTH = 4096;

    typedef logic [1:0] mem_len_t;

    localparam mem_len_t mem_len_byte = 2'b00;
    localparam mem_len_t mem_len_half = 2'b01;
    localparam mem_len_t mem_len_word = 2'b10;

    // An address is in range when every bit above the word index is zero.
    function automatic logic addr_in_range(input logic [RAM_ADDR_BUS-1:0] addr,
                                           input int                      addr_w);
        return (addr >> (addr_w + 2)) == '0;
    endfunction

endpackage

// File: rtl/data_mem_lane.sv
// Store-lane decode: turns byte offset, access length and store data into
// per-byte enables, lane-replicated write data and an alignment error flag.
module data_mem_lane
    import data_mem_pkg::*;
(
    input  logic [1:0]              i_addr_lo,
    input  mem_len_t                i_len,
    input  logic [RAM_DATA_BUS-1:0] i_w_data,
    output logic [3:0]              o_be,
    output logic [RAM_DATA_BUS-1:0] o_lane_data,
    output logic                    o_misalign
);

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        o_be        = 4'b1111;
        o_lane_data = i_w_data;
        o_misalign  = 1'b0;
        case (i_len)
            mem_len_byte: begin
                o_be        = 4'b0001 << i_addr_lo;
                o_lane_data = {4{i_w_data[7:0]}};
            end
            mem_len_half: begin
                o_be        = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_lane_data = {2{i_w_data[15:0]}};
                o_misalign  = i_addr_lo[0];
            end
            mem_len_word: begin
                o_misalign  = |i_addr_lo;
            end
            default: begin
                // 2'b11 behaves as a word access
                o_misalign  = |i_addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/data_mem.sv
// Data RAM behind the execute stage: byte-masked synchronous writes, one-cycle
// registered full-word reads with write-first forwarding, and error reporting.
module data_mem
    import data_mem_pkg::*;
#(
    parameter int DEPTH     = DATA_MEM_DEPTH,
    parameter int ADDR_W    = 12,
    parameter     INIT_FILE = ""
) (
    input  logic                    i_Clk,
    input  logic                    i_reset,
    input  logic                    i_mem_we,
    input  logic [RAM_ADDR_BUS-1:0] i_mem_r_addr,
    input  logic [RAM_ADDR_BUS-1:0] i_mem_w_addr,
    input  logic [RAM_DATA_BUS-1:0] i_mem_w_data,
    input  mem_len_t                i_mem_len,
    output logic [RAM_DATA_BUS-1:0] o_mem_r_data,
    output logic [RAM_ADDR_BUS-1:0] o_mem_r_addr,
    output logic                    o_misalign,
    output logic                    o_oob,
    output logic [RAM_ADDR_BUS-1:0] o_err_addr
);

    logic [RAM_DATA_BUS-1:0] r_mem [0:DEPTH-1];

    logic [3:0]              w_be;
    logic [RAM_DATA_BUS-1:0] w_lane_data;
    logic                    w_lane_misalign;

    data_mem_lane u_lane (
        .i_addr_lo   (i_mem_w_addr[1:0]),
        .i_len       (i_mem_len),
        .i_w_data    (i_mem_w_data),
        .o_be        (w_be),
        .o_lane_data (w_lane_data),
        .o_misalign  (w_lane_misalign)
    );

    logic [ADDR_W-1:0] w_r_idx;
    logic [ADDR_W-1:0] w_w_idx;
    logic              w_rd_oob;
    logic              w_wr_oob;
    logic              w_wr_misalign;
    logic              w_wr_ok;

    assign w_r_idx       = i_mem_r_addr[ADDR_W+1:2];
    assign w_w_idx       = i_mem_w_addr[ADDR_W+1:2];
    assign w_rd_oob      = !addr_in_range(i_mem_r_addr, ADDR_W);
    assign w_wr_oob      = i_mem_we && !addr_in_range(i_mem_w_addr, ADDR_W);
    assign w_wr_misalign = i_mem_we && w_lane_misalign;
    assign w_wr_ok       = i_mem_we && !w_wr_oob && !w_lane_misalign;

    // Write-first: a same-word store in this cycle overrides the enabled bytes.
    logic [RAM_DATA_BUS-1:0] w_rd_merged;
    always_comb begin
        w_rd_merged = r_mem[w_r_idx];
        if (w_wr_ok && (w_w_idx == w_r_idx)) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) w_rd_merged[8*b +: 8] = w_lane_data[8*b +: 8];
            end
        end
    end

    // NOTE: the array has no reset branch; clearing it would forbid RAM inference.
    always_ff @(posedge i_Clk) begin
        if (!i_reset && w_wr_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_w_idx][8*b +: 8] <= w_lane_data[8*b +: 8];
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so all registers sample together.
    always_ff @(posedge i_Clk or posedge i_reset) begin
        if (i_reset) begin
            o_mem_r_data <= '0;
            o_mem_r_addr <= '0;
            o_misalign   <= 1'b0;
            o_oob        <= 1'b0;
            o_err_addr   <= '0;
        end else begin
            o_mem_r_data <= w_rd_oob ? '0 : w_rd_merged;
            o_mem_r_addr <= i_mem_r_addr;
            o_misalign   <= w_wr_misalign;
            o_oob        <= w_wr_oob || w_rd_oob;
            if (w_wr_misalign || w_wr_oob)
                o_err_addr <= i_mem_w_addr;
            else if (w_rd_oob)
                o_err_addr <= i_mem_r_addr;
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem: a byte-addressed reference model predicts each
// cycle's response, a monitor pops and compares one cycle later.
module tb_data_mem;
    import data_mem_pkg::*;

    logic        i_Clk   = 1'b0;
    logic        i_reset = 1'b1;
    logic        we      = 1'b0;
    logic [31:0] r_addr  = '0;
    logic [31:0] w_addr  = '0;
    logic [31:0] w_data  = '0;
    logic [1:0]  len     = 2'b00;

    logic [31:0] o_mem_r_data;
    logic [31:0] o_mem_r_addr;
    logic        o_misalign;
    logic        o_oob;
    logic [31:0] o_err_addr;

    data_mem #(.DEPTH(4096), .ADDR_W(12), .INIT_FILE("")) dut (
        .i_Clk        (i_Clk),
        .i_reset      (i_reset),
        .i_mem_we     (we),
        .i_mem_r_addr (r_addr),
        .i_mem_w_addr (w_addr),
        .i_mem_w_data (w_data),
        .i_mem_len    (len),
        .o_mem_r_data (o_mem_r_data),
        .o_mem_r_addr (o_mem_r_addr),
        .o_misalign   (o_misalign),
        .o_oob        (o_oob),
        .o_err_addr   (o_err_addr)
    );

    always #5 i_Clk = ~i_Clk;

    typedef struct packed {
        logic [31:0] r_data;
        logic [31:0] r_addr;
        logic        misalign;
        logic        oob;
        logic [31:0] err_addr;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  m_bytes [0:16383];
    logic [31:0] m_err   = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one request and predict its response from byte-level memory rules.
    task automatic issue(input bit we_i, input logic [31:0] ra, input logic [31:0] wa,
                         input logic [31:0] wd, input logic [1:0] ln);
        exp_t        e;
        int          nbytes;
        bit          mis, woob, roob;
        logic [31:0] base;
        @(negedge i_Clk);
        we = we_i; r_addr = ra; w_addr = wa; w_data = wd; len = ln;
        nbytes = (ln == 2'b00) ? 1 : (ln == 2'b01) ? 2 : 4;
        mis  = we_i && ((wa % nbytes) != 0);
        woob = we_i && (wa >= 32'h4000);
        roob = (ra >= 32'h4000);
        if (we_i && !mis && !woob)
            for (int k = 0; k < nbytes; k++) m_bytes[wa + k] = wd[8*k +: 8];
        if (mis || woob) m_err = wa;
        else if (roob)   m_err = ra;
        base = ra & ~32'd3;
        e.r_data   = roob ? 32'd0 : {m_bytes[base+3], m_bytes[base+2], m_bytes[base+1], m_bytes[base]};
        e.r_addr   = ra;
        e.misalign = mis;
        e.oob      = woob || roob;
        e.err_addr = m_err;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge i_Clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("r_data",   o_mem_r_data,              e.r_data);
                check("r_addr",   o_mem_r_addr,              e.r_addr);
                check("misalign", {31'd0, o_misalign},       {31'd0, e.misalign});
                check("oob",      {31'd0, o_oob},            {31'd0, e.oob});
                check("err_addr", o_err_addr,                e.err_addr);
            end
        end
    end

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 9) < 8) return $urandom_range(0, 255);
        return ($urandom_range(0, 1) == 0) ? 32'h4000 + $urandom_range(0, 4095) : ($urandom | 32'h8000_0000);
    endfunction

    initial begin : stim
        for (int i = 0; i < 16384; i++) m_bytes[i] = 8'h00;

        // Reset state
        repeat (2) @(posedge i_Clk);
        #1;
        check("rst_r_data",   o_mem_r_data,        32'd0);
        check("rst_r_addr",   o_mem_r_addr,        32'd0);
        check("rst_misalign", {31'd0, o_misalign}, 32'd0);
        check("rst_oob",      {31'd0, o_oob},      32'd0);
        check("rst_err_addr", o_err_addr,          32'd0);
        @(negedge i_Clk);
        i_reset = 1'b0;

        // Known contents for the low 256 bytes used by all later reads
        for (int i = 0; i < 64; i++) issue(1'b1, 32'(4*i), 32'(4*i), 32'd0, 2'b10);

        // Word store then read
        issue(1'b1, 32'h0, 32'h10, 32'hDEADBEEF, 2'b10);
        issue(1'b0, 32'h10, 32'h0, 32'h0, 2'b00);
        // Byte and half stores over a known word
        issue(1'b1, 32'h0, 32'h10, 32'h11223344, 2'b10);
        issue(1'b1, 32'h0, 32'h13, 32'h000000A5, 2'b00);
        issue(1'b0, 32'h10, 32'h0, 32'h0, 2'b00);
        issue(1'b1, 32'h0, 32'h12, 32'h0000BEEF, 2'b01);
        issue(1'b0, 32'h10, 32'h0, 32'h0, 2'b00);
        // Misaligned word store dropped, byte store to same word lands
        issue(1'b1, 32'h0, 32'h22, 32'hCAFEF00D, 2'b10);
        issue(1'b0, 32'h20, 32'h0, 32'h0, 2'b00);
        issue(1'b1, 32'h0, 32'h23, 32'h00000099, 2'b00);
        issue(1'b0, 32'h20, 32'h0, 32'h0, 2'b00);
        issue(1'b1, 32'h0, 32'h21, 32'h00001234, 2'b01);
        // Same-cycle write-first
        issue(1'b1, 32'h40, 32'h40, 32'h00000077, 2'b00);
        // Out-of-range read and write
        issue(1'b0, 32'h4000, 32'h0, 32'h0, 2'b00);
        issue(1'b1, 32'h0, 32'h4000, 32'h12345678, 2'b10);
        issue(1'b1, 32'h4004, 32'h4002, 32'h1, 2'b10);

        for (int n = 0; n < 400; n++)
            issue(1'($urandom_range(0, 1)), rand_addr(), rand_addr(), $urandom, 2'($urandom_range(0, 3)));

        // Reset asserted while a read is in flight; a write during reset must not land
        issue(1'b1, 32'h10, 32'h14, 32'h0BADF00D, 2'b10);
        @(posedge i_Clk);
        #1;
        @(negedge i_Clk);
        we = 1'b0; r_addr = 32'h14;
        #2;
        i_reset = 1'b1;
        #1;
        check("rst_mid_r_data",   o_mem_r_data,        32'd0);
        check("rst_mid_r_addr",   o_mem_r_addr,        32'd0);
        check("rst_mid_misalign", {31'd0, o_misalign}, 32'd0);
        check("rst_mid_oob",      {31'd0, o_oob},      32'd0);
        check("rst_mid_err_addr", o_err_addr,          32'd0);
        we = 1'b1; w_addr = 32'h14; w_data = 32'hFFFFFFFF; len = 2'b10;
        @(posedge i_Clk);
        #1;
        check("rst_hold_r_data", o_mem_r_data, 32'd0);
        check("rst_hold_r_addr", o_mem_r_addr, 32'd0);
        @(negedge i_Clk);
        i_reset = 1'b0;
        we      = 1'b0;
        m_err   = '0;
        issue(1'b0, 32'h14, 32'h0, 32'h0, 2'b00);
        issue(1'b0, 32'h10, 32'h0, 32'h0, 2'b00);

        repeat (4) @(posedge i_Clk);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
